// File: rtl/rapid_pkg.sv
// Shared types and constants for the RAPID core front end.
package rapid_pkg;

    localparam int unsigned RAPID_XLEN = 32;

    // First fetch address after reset.
    localparam logic [RAPID_XLEN-1:0] RAPID_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [RAPID_XLEN-1:0] instruction;
        logic [RAPID_XLEN-1:0] pc;
    } fetch_entry_s;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush empties it and wins over push/pop.
module fetch_fifo
    import rapid_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_push,
    input  fetch_entry_s i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [AW:0]  o_count,
    output fetch_entry_s o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_s r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !i_flush && (r_count != FULL_CNT);
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    // Storage write; cleared on reset so the head reads zero until the first push.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single outstanding imem read, buffered
// (instruction, pc) hand-off to the decoder, redirect with in-flight discard.
module fetch_unit
    import rapid_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = RAPID_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic            i_imem_valid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_instruction,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fault
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    // Address of the current/last request; held stable while the request is pending.
    logic [XLEN-1:0] r_req_pc;
    logic            r_discard;
    // A misaligned redirect arrived mid-transaction: park in HALT once it completes.
    logic            r_halt_pend;
    logic            r_fault;

    logic            w_misaligned;
    logic            w_push;
    logic            w_pop;
    logic            w_space;
    logic [CW-1:0]   w_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_unused_full;
    fetch_entry_s    w_push_data;
    fetch_entry_s    w_head;

    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
    // A response in the redirect cycle is stale by definition, so never push it.
    assign w_push  = (r_state == WAIT) && i_imem_valid && !r_discard && !i_redirect;
    assign w_pop   = !w_fifo_empty && i_ready;
    // One read outstanding at most, so free space now guarantees room for its response.
    assign w_space = (w_count < CNT_MAX);

    assign w_push_data.instruction = i_imem_rdata;
    assign w_push_data.pc          = r_req_pc;
    assign w_unused_full           = w_fifo_full;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Fetch sequencer: state, PC, discard/halt tracking and the fault flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_discard   <= 1'b0;
            r_halt_pend <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            if (i_redirect) begin
                r_fetch_pc  <= i_redirect_pc;
                r_fault     <= w_misaligned;
                r_halt_pend <= w_misaligned;
            end
            case (r_state)
                IDLE: begin
                    if (i_redirect) begin
                        r_state <= w_misaligned ? HALT : IDLE;
                    end else if (w_space) begin
                        r_state  <= REQ;
                        r_req_pc <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (i_redirect) begin
                        r_discard <= 1'b1;
                    end
                    if (i_imem_ack) begin
                        r_state <= WAIT;
                        // After an earlier redirect fetch_pc already holds the new target.
                        if (!i_redirect && !r_discard) begin
                            r_fetch_pc <= r_fetch_pc + XLEN'(4);
                        end
                    end
                end
                WAIT: begin
                    if (i_imem_valid) begin
                        r_discard <= 1'b0;
                        if (i_redirect) begin
                            r_state <= w_misaligned ? HALT : IDLE;
                        end else begin
                            r_state <= r_halt_pend ? HALT : IDLE;
                        end
                    end else if (i_redirect) begin
                        r_discard <= 1'b1;
                    end
                end
                HALT: begin
                    if (i_redirect && !w_misaligned) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_imem_req    = (r_state == REQ);
    assign o_imem_addr   = r_req_pc;
    assign o_valid       = !w_fifo_empty;
    assign o_instruction = w_head.instruction;
    assign o_pc          = w_head.pc;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a program-order model of the delivered (pc, instruction) stream.
module tb_fetch_unit;
    import rapid_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b1;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ack = 1'b0;
    logic            i_imem_valid = 1'b0;
    logic [XLEN-1:0] i_imem_rdata = '0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [XLEN-1:0] o_instruction;
    logic [XLEN-1:0] o_pc;
    logic            i_redirect = 1'b0;
    logic [XLEN-1:0] i_redirect_pc = '0;
    logic            o_fault;

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_valid  (i_imem_valid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fault       (o_fault)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: next pc the decoder must see, and the expected fault flag.
    logic [31:0] exp_pc = 32'h0;
    bit          exp_fault = 1'b0;
    int          n_pops = 0;
    logic [31:0] last_pop_pc = 32'h0;
    logic [31:0] ack_q [$];

    // Memory responder state and knobs.
    bit          in_req = 1'b0;
    logic [31:0] held_addr = 32'h0;
    int          ack_wait = 0;
    bit          rsp_pending = 1'b0;
    int          rsp_wait = 0;
    logic [31:0] rsp_addr = 32'h0;
    int          ack_max = 0;
    int          rsp_max = 0;
    int          rsp_fixed = 0;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    int          hold_cycles = 0;
    bit          data_zero = 1'b1;
    bit          lat_chk = 1'b0;
    bit          inject_valid = 1'b0;
    bit          redir_req = 1'b0;
    logic [31:0] redir_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_zero) return 32'h0000_0013;
        return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] ack_at(input int i);
        if (i < ack_q.size()) return ack_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_pc      = 32'h0;
        exp_fault   = 1'b0;
        n_pops      = 0;
        in_req      = 1'b0;
        rsp_pending = 1'b0;
        ack_q.delete();
        i_imem_ack   = 1'b0;
        i_imem_valid = 1'b0;
        i_redirect   = 1'b0;
        redir_req    = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        clear_model();
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
    endtask

    // One clock: drive memory/consumer/redirect from outputs seen at the sample point.
    task automatic step();
        bit drove_valid;
        drove_valid  = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_valid = 1'b0;
        if (inject_valid) begin
            i_imem_valid = 1'b1;
            i_imem_rdata = 32'hDEAD_BEEF;
            inject_valid = 1'b0;
        end else if (rsp_pending) begin
            if (rsp_wait == 0) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = mem_word(rsp_addr);
                rsp_pending  = 1'b0;
                drove_valid  = 1'b1;
            end else begin
                rsp_wait--;
            end
        end
        if (o_imem_req) begin
            check("addr_align", {30'b0, o_imem_addr[1:0]}, 32'h0);
            if (!in_req) begin
                in_req    = 1'b1;
                held_addr = o_imem_addr;
                ack_wait  = (o_imem_addr == hold_addr) ? hold_cycles
                                                       : int'($urandom_range(0, ack_max));
            end else begin
                check("addr_stable", o_imem_addr, held_addr);
            end
            if (ack_wait == 0) begin
                i_imem_ack  = 1'b1;
                in_req      = 1'b0;
                ack_q.push_back(o_imem_addr);
                rsp_pending = 1'b1;
                rsp_addr    = o_imem_addr;
                rsp_wait    = (rsp_fixed >= 0) ? rsp_fixed : int'($urandom_range(0, rsp_max));
            end else begin
                ack_wait--;
            end
        end
        i_redirect = 1'b0;
        if (redir_req) begin
            i_redirect    = 1'b1;
            i_redirect_pc = redir_pc;
            redir_req     = 1'b0;
        end
        if (o_valid && i_ready && !i_redirect) begin
            check("pop_pc", o_pc, exp_pc);
            check("pop_instr", o_instruction, mem_word(exp_pc));
            last_pop_pc = o_pc;
            exp_pc      = exp_pc + 32'd4;
            n_pops++;
        end
        if (i_redirect) begin
            exp_pc    = i_redirect_pc;
            exp_fault = (i_redirect_pc[1:0] != 2'b00);
        end
        if (lat_chk && drove_valid) check("no_bypass", {31'b0, o_valid}, 32'h0);
        @(posedge i_clk); #1;
        if (lat_chk && drove_valid) check("valid_latency", {31'b0, o_valid}, 32'h1);
        check("fault_state", {31'b0, o_fault}, {31'b0, exp_fault});
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until_acks(input int n, input string tag);
        int b;
        b = 300;
        while (ack_q.size() < n && b > 0) begin
            step();
            b--;
        end
        check({tag, "_ack_budget"}, (ack_q.size() >= n) ? 32'h1 : 32'h0, 32'h1);
    endtask

    task automatic run_until_pops(input int n, input string tag);
        int b;
        b = 300;
        while (n_pops < n && b > 0) begin
            step();
            b--;
        end
        check({tag, "_pop_budget"}, (n_pops >= n) ? 32'h1 : 32'h0, 32'h1);
    endtask

    initial begin
        int base;
        int b;
        bit halted;
        logic [31:0] tgt;

        // Reset values.
        #1 i_reset_n = 1'b0;
        clear_model();
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("rst_req", {31'b0, o_imem_req}, 32'h0);
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_instr", o_instruction, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_fault", {31'b0, o_fault}, 32'h0);

        // Zero-wait memory, NOP everywhere.
        data_zero = 1'b1; ack_max = 0; rsp_fixed = 0; i_ready = 1'b1; lat_chk = 1'b1;
        i_reset_n = 1'b1;
        check("t1_no_req_cycle1", {31'b0, o_imem_req}, 32'h0);
        step();
        check("t1_first_req", {31'b0, o_imem_req}, 32'h1);
        check("t1_first_addr", o_imem_addr, 32'h0);
        run_until_pops(3, "t1");
        check("t1_ack0", ack_at(0), 32'h0);
        check("t1_ack1", ack_at(1), 32'h4);
        check("t1_ack2", ack_at(2), 32'h8);
        lat_chk = 1'b0;

        // Back-pressure fills the buffer and stops fetching.
        data_zero = 1'b0; i_ready = 1'b0;
        do_reset();
        run_steps(20);
        check("t2_acks", ack_q.size(), DEPTH);
        check("t2_req_idle", {31'b0, o_imem_req}, 32'h0);
        check("t2_valid", {31'b0, o_valid}, 32'h1);
        check("t2_head_pc", o_pc, 32'h0);
        check("t2_head_instr", o_instruction, mem_word(32'h0));
        i_ready = 1'b1;
        run_until_pops(2, "t2");
        run_until_acks(3, "t2");
        check("t2_resume_addr", ack_at(2), 32'h8);

        // Redirect while waiting for the response to 0x4.
        rsp_fixed = 3;
        do_reset();
        run_until_acks(2, "t3");
        check("t3_wait_addr", ack_at(1), 32'h4);
        redir_pc = 32'h100; redir_req = 1'b1;
        step();
        check("t3_flushed", {31'b0, o_valid}, 32'h0);
        run_until_acks(3, "t3b");
        check("t3_next_addr", ack_at(2), 32'h100);
        base = n_pops;
        run_until_pops(base + 1, "t3");
        check("t3_next_pc", last_pop_pc, 32'h100);

        // Redirect while a request waits 3 cycles for its ack.
        rsp_fixed = 0; hold_addr = 32'h4; hold_cycles = 3;
        do_reset();
        b = 100;
        while (!(o_imem_req && o_imem_addr == 32'h4) && b > 0) begin
            step();
            b--;
        end
        check("t4_req4_seen", {31'b0, o_imem_req}, 32'h1);
        redir_pc = 32'h200; redir_req = 1'b1;
        step();
        check("t4_req_held", {31'b0, o_imem_req}, 32'h1);
        check("t4_addr_held", o_imem_addr, 32'h4);
        run_until_acks(2, "t4");
        check("t4_ack_old", ack_at(1), 32'h4);
        run_until_acks(3, "t4b");
        check("t4_ack_new", ack_at(2), 32'h200);
        base = n_pops;
        run_until_pops(base + 1, "t4");
        check("t4_next_pc", last_pop_pc, 32'h200);
        hold_addr = 32'hFFFF_FFFF;

        // Misaligned redirect halts; an aligned one resumes.
        redir_pc = 32'h102; redir_req = 1'b1;
        step();
        check("t5_fault_set", {31'b0, o_fault}, 32'h1);
        run_steps(8);
        base = ack_q.size();
        run_steps(10);
        check("t5_no_acks", ack_q.size(), base);
        check("t5_no_req", {31'b0, o_imem_req}, 32'h0);
        check("t5_no_valid", {31'b0, o_valid}, 32'h0);
        redir_pc = 32'h300; redir_req = 1'b1;
        step();
        check("t5_fault_clr", {31'b0, o_fault}, 32'h0);
        run_until_acks(base + 1, "t5");
        check("t5_resume_addr", ack_at(base), 32'h300);
        base = n_pops;
        run_until_pops(base + 1, "t5");
        check("t5_resume_pc", last_pop_pc, 32'h300);

        // Asynchronous reset during WAIT with one entry buffered.
        i_ready = 1'b0; rsp_fixed = 3;
        do_reset();
        run_until_acks(2, "t6");
        check("t6_buffered", {31'b0, o_valid}, 32'h1);
        #2 i_reset_n = 1'b0;
        #1;
        check("t6_req", {31'b0, o_imem_req}, 32'h0);
        check("t6_addr", o_imem_addr, 32'h0);
        check("t6_valid", {31'b0, o_valid}, 32'h0);
        check("t6_instr", o_instruction, 32'h0);
        check("t6_pc", o_pc, 32'h0);
        check("t6_fault", {31'b0, o_fault}, 32'h0);
        clear_model();
        @(posedge i_clk); #1;
        i_reset_n = 1'b1; i_ready = 1'b1; rsp_fixed = 0; inject_valid = 1'b1;
        step();
        check("t6_late_ignored", {31'b0, o_valid}, 32'h0);
        run_until_acks(1, "t6b");
        check("t6_first_addr", ack_at(0), 32'h0);
        run_until_pops(1, "t6");

        // Randomized traffic with random latencies, back-pressure and redirects.
        ack_max = 2; rsp_fixed = -1; rsp_max = 3;
        do_reset();
        halted = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            i_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                tgt = $urandom & 32'h0000_FFFC;
                if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
                if (!halted && $urandom_range(0, 5) == 0) begin
                    tgt    = tgt | 32'(1 + $urandom_range(0, 2));
                    halted = 1'b1;
                end else begin
                    halted = 1'b0;
                end
                redir_pc  = tgt;
                redir_req = 1'b1;
            end
            step();
        end
        check("rand_progress", (n_pops >= 100) ? 32'h1 : 32'h0, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
